// File: rtl/asip_pkg.sv
// Shared ASIP decode definitions: field widths, opcode constants, FSM state
// encoding, the ID/EX slot payload and the opcode class functions.
package asip_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned IMM_W   = 8;
  localparam int unsigned PC_W    = 8;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned FLUSH_W = 2;

  // Cycles discarded after a taken branch (fetch redirect lands one cycle late)
  localparam logic [FLUSH_W-1:0] FLUSH_CYCLES = FLUSH_W'(2);

  localparam logic [OP_W-1:0] OP_ALU_LO = 4'h1;
  localparam logic [OP_W-1:0] OP_ALU_HI = 4'hB;
  localparam logic [OP_W-1:0] OP_STORE  = 4'hC;
  localparam logic [OP_W-1:0] OP_BR     = 4'hF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [IMM_W-1:0] imm;
  } ex_slot_t;

  // ALU ops 0x1..0xB write rd
  function automatic logic writesRd(input logic [OP_W-1:0] op);
    return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
  endfunction

  // Stores read rd as their data source
  function automatic logic readsRd(input logic [OP_W-1:0] op);
    return op == OP_STORE;
  endfunction

  function automatic logic readsRa(input logic [OP_W-1:0] op);
    return writesRd(op) || (op == OP_STORE);
  endfunction

  function automatic logic readsRb(input logic [OP_W-1:0] op);
    return writesRd(op);
  endfunction

  function automatic logic isBranch(input logic [OP_W-1:0] op);
    return op == OP_BR;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch <-> decode <-> execute bus for the decode stage.
//   instruction : fetch word for the PC being loaded this cycle
//   stall       : hold PC/instruction
//   pcWrEn/newPc: one-cycle redirect to fetch
//   ex*         : registered ID/EX slot
// master = decode stage, slave = surrounding pipeline.
interface decode_stage_if;

  logic [asip_pkg::INSTR_W-1:0] instruction;
  logic                         stall;
  logic                         pcWrEn;
  logic [asip_pkg::PC_W-1:0]    newPc;
  logic                         exValid;
  logic [asip_pkg::OP_W-1:0]    exOpcode;
  logic [asip_pkg::REG_W-1:0]   exRd;
  logic [asip_pkg::REG_W-1:0]   exRa;
  logic [asip_pkg::REG_W-1:0]   exRb;
  logic [asip_pkg::IMM_W-1:0]   exImm;

  modport master (
    input  instruction,
    output stall, pcWrEn, newPc,
    output exValid, exOpcode, exRd, exRa, exRb, exImm
  );

  modport slave (
    output instruction,
    input  stall, pcWrEn, newPc,
    input  exValid, exOpcode, exRd, exRa, exRb, exImm
  );

endinterface

// File: rtl/pipe_reg.sv
// Pipeline register with synchronous clear used to insert bubbles.
//   clk, reset (async active-low), clr (load zero), d -> q
module pipe_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/scoreboard.sv
// Register busy scoreboard: one down-counter per architectural register.
//   issue       : a writer of rd is issuing this cycle
//   rd, ra, rb  : register fields of the instruction under decode
//   re_*        : which of those fields the instruction actually reads
//   hazard      : a read register is still pending (combinational)
module scoreboard
  import asip_pkg::*;
#(
  parameter int unsigned WB_LAT = 3,
  parameter int unsigned NREG   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] ra,
  input  logic [REG_W-1:0] rb,
  input  logic             re_rd,
  input  logic             re_ra,
  input  logic             re_rb,
  output logic             hazard
);

  logic [CNT_W-1:0] cnt [NREG];

  // Load on issue beats the free-running decrement; r0 is never tracked
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (issue && (rd == REG_W'(i)) && (i != 0)) begin
          cnt[i] <= CNT_W'(WB_LAT);
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // Hazard when any enabled source register has a live counter
  always_comb begin
    hazard = 1'b0;
    if (re_rd && (rd != '0) && (cnt[rd] != '0)) hazard = 1'b1;
    if (re_ra && (ra != '0) && (cnt[ra] != '0)) hazard = 1'b1;
    if (re_rb && (rb != '0) && (cnt[rb] != '0)) hazard = 1'b1;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field decode, RAW-hazard stall, branch redirect with a
// two-cycle flush, and the ID/EX register.
//   clk, reset (async active-low)
//   bus.master : instruction in; stall/pcWrEn/newPc combinational out;
//                ex* registered out (one cycle after the instruction)
module decode_stage
  import asip_pkg::*;
#(
  parameter int unsigned WB_LAT = 3,
  parameter int unsigned NREG   = 16
) (
  input  logic           clk,
  input  logic           reset,
  decode_stage_if.master bus
);

  logic [OP_W-1:0]    op;
  logic [REG_W-1:0]   rd;
  logic [REG_W-1:0]   ra;
  logic [REG_W-1:0]   rb;
  logic [IMM_W-1:0]   imm;

  state_t             state;
  logic [FLUSH_W-1:0] flush_cnt;

  logic               active;
  logic               hazard;
  logic               branch;
  logic               issue;
  logic               sb_load;

  ex_slot_t           ex_d;
  ex_slot_t           ex_q;

  assign {op, rd, ra, rb} = bus.instruction;
  assign imm              = bus.instruction[IMM_W-1:0];

  // Decoding is live outside reset and outside the flush window
  assign active  = reset && (state != FLUSH);
  assign branch  = isBranch(op);
  assign issue   = active && !hazard;
  assign sb_load = issue && writesRd(op);

  scoreboard #(
    .WB_LAT (WB_LAT),
    .NREG   (NREG)
  ) u_scoreboard (
    .clk    (clk),
    .reset  (reset),
    .issue  (sb_load),
    .rd     (rd),
    .ra     (ra),
    .rb     (rb),
    .re_rd  (readsRd(op)),
    .re_ra  (readsRa(op)),
    .re_rb  (readsRb(op)),
    .hazard (hazard)
  );

  // Fetch control: stall and redirect are mutually exclusive by construction
  always_comb begin
    bus.stall  = 1'b0;
    bus.pcWrEn = 1'b0;
    bus.newPc  = '0;
    if (active) begin
      if (hazard) begin
        bus.stall = 1'b1;
      end else if (branch) begin
        bus.pcWrEn = 1'b1;
        bus.newPc  = PC_W'(imm);
      end
    end
  end

  // Control FSM; STALL re-evaluates the held word exactly like RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN, STALL: begin
          if (hazard) begin
            state <= STALL;
          end else if (branch) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_CYCLES;
          end else begin
            state <= RUN;
          end
        end
        FLUSH: begin
          if (flush_cnt > FLUSH_W'(1)) begin
            flush_cnt <= flush_cnt - FLUSH_W'(1);
          end else begin
            flush_cnt <= '0;
            state     <= RUN;
          end
        end
        default: begin
          state     <= RUN;
          flush_cnt <= '0;
        end
      endcase
    end
  end

  assign ex_d = '{valid: 1'b1, opcode: op, rd: rd, ra: ra, rb: rb, imm: imm};

  // ID/EX slot; anything not issuing becomes a bubble
  pipe_reg #(
    .W ($bits(ex_slot_t))
  ) u_id_ex (
    .clk   (clk),
    .reset (reset),
    .clr   (!issue),
    .d     (ex_d),
    .q     (ex_q)
  );

  assign bus.exValid  = ex_q.valid;
  assign bus.exOpcode = ex_q.opcode;
  assign bus.exRd     = ex_q.rd;
  assign bus.exRa     = ex_q.ra;
  assign bus.exRb     = ex_q.rb;
  assign bus.exImm    = ex_q.imm;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage (WB_LAT = 3, NREG = 16).
module tb_decode_stage;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  // Expected ID/EX slot {exValid, opcode, rd, ra, rb, imm}, one per driven cycle
  logic [24:0] exp_q [$];

  typedef struct packed {
    logic [15:0] w;
    logic        st;
    logic        pw;
    logic [7:0]  pc;
    logic        iss;
  } cyc_t;

  decode_stage_if bus ();

  decode_stage #(
    .WB_LAT (3),
    .NREG   (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [24:0] ex_now();
    return {bus.exValid, bus.exOpcode, bus.exRd, bus.exRa, bus.exRb, bus.exImm};
  endfunction

  // An issued word appears on ex* with all fields taken straight from the word
  function automatic logic [24:0] exp_of(input logic [15:0] w, input logic iss);
    return iss ? {1'b1, w, w[7:0]} : 25'd0;
  endfunction

  task automatic drive(input logic [15:0] w, input logic iss);
    @(negedge clk);
    bus.instruction = w;
    exp_q.push_back(exp_of(w, iss));
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.instruction = 16'h0000;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.instruction = 16'hF040;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.stall, bus.pcWrEn, bus.newPc} !== 10'd0) begin
      errors++;
      $display("FAIL reset ctrl: stall/pcWrEn/newPc got %b/%b/%h want 0/0/00", bus.stall, bus.pcWrEn, bus.newPc);
    end
    checks++;
    if (ex_now() !== 25'd0) begin
      errors++;
      $display("FAIL reset ex: got %h want 0000000", ex_now());
    end
  endtask

  task automatic test_back_to_back();
    cyc_t seq [4];
    logic [24:0] exp;
    seq = '{'{16'h1123, 1'b0, 1'b0, 8'h00, 1'b1},
            '{16'h2456, 1'b0, 1'b0, 8'h00, 1'b1},
            '{16'h0410, 1'b0, 1'b0, 8'h00, 1'b1},
            '{16'hD41F, 1'b0, 1'b0, 8'h00, 1'b1}};
    do_reset();
    foreach (seq[i]) begin
      drive(seq[i].w, seq[i].iss);
      checks++;
      if (bus.stall !== seq[i].st || bus.pcWrEn !== seq[i].pw || (seq[i].pw && bus.newPc !== seq[i].pc)) begin
        errors++;
        $display("FAIL b2b ctrl[%0d]: stall/pcWrEn/newPc got %b/%b/%h want %b/%b/%h", i, bus.stall, bus.pcWrEn, bus.newPc, seq[i].st, seq[i].pw, seq[i].pc);
      end
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (ex_now() !== exp) begin
        errors++;
        $display("FAIL b2b ex[%0d]: got %h want %h", i, ex_now(), exp);
      end
    end
  endtask

  task automatic test_raw();
    cyc_t seq [5];
    logic [24:0] exp;
    seq = '{'{16'h1312, 1'b0, 1'b0, 8'h00, 1'b1},
            '{16'h2435, 1'b1, 1'b0, 8'h00, 1'b0},
            '{16'h2435, 1'b1, 1'b0, 8'h00, 1'b0},
            '{16'h2435, 1'b1, 1'b0, 8'h00, 1'b0},
            '{16'h2435, 1'b0, 1'b0, 8'h00, 1'b1}};
    do_reset();
    foreach (seq[i]) begin
      drive(seq[i].w, seq[i].iss);
      checks++;
      if (bus.stall !== seq[i].st || bus.pcWrEn !== seq[i].pw || (seq[i].pw && bus.newPc !== seq[i].pc)) begin
        errors++;
        $display("FAIL raw ctrl[%0d]: stall/pcWrEn/newPc got %b/%b/%h want %b/%b/%h", i, bus.stall, bus.pcWrEn, bus.newPc, seq[i].st, seq[i].pw, seq[i].pc);
      end
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (ex_now() !== exp) begin
        errors++;
        $display("FAIL raw ex[%0d]: got %h want %h", i, ex_now(), exp);
      end
    end
  endtask

  // Store ignores rb but waits on rd; the counter keeps draining meanwhile
  task automatic test_store();
    cyc_t seq [5];
    logic [24:0] exp;
    seq = '{'{16'h1500, 1'b0, 1'b0, 8'h00, 1'b1},
            '{16'hC305, 1'b0, 1'b0, 8'h00, 1'b1},
            '{16'hC530, 1'b1, 1'b0, 8'h00, 1'b0},
            '{16'hC530, 1'b1, 1'b0, 8'h00, 1'b0},
            '{16'hC530, 1'b0, 1'b0, 8'h00, 1'b1}};
    do_reset();
    foreach (seq[i]) begin
      drive(seq[i].w, seq[i].iss);
      checks++;
      if (bus.stall !== seq[i].st || bus.pcWrEn !== seq[i].pw || (seq[i].pw && bus.newPc !== seq[i].pc)) begin
        errors++;
        $display("FAIL store ctrl[%0d]: stall/pcWrEn/newPc got %b/%b/%h want %b/%b/%h", i, bus.stall, bus.pcWrEn, bus.newPc, seq[i].st, seq[i].pw, seq[i].pc);
      end
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (ex_now() !== exp) begin
        errors++;
        $display("FAIL store ex[%0d]: got %h want %h", i, ex_now(), exp);
      end
    end
  endtask

  task automatic test_branch();
    cyc_t seq [4];
    logic [24:0] exp;
    seq = '{'{16'hF040, 1'b0, 1'b1, 8'h40, 1'b1},
            '{16'h1123, 1'b0, 1'b0, 8'h00, 1'b0},
            '{16'h2456, 1'b0, 1'b0, 8'h00, 1'b0},
            '{16'h3789, 1'b0, 1'b0, 8'h00, 1'b1}};
    do_reset();
    foreach (seq[i]) begin
      drive(seq[i].w, seq[i].iss);
      checks++;
      if (bus.stall !== seq[i].st || bus.pcWrEn !== seq[i].pw || (seq[i].pw && bus.newPc !== seq[i].pc)) begin
        errors++;
        $display("FAIL branch ctrl[%0d]: stall/pcWrEn/newPc got %b/%b/%h want %b/%b/%h", i, bus.stall, bus.pcWrEn, bus.newPc, seq[i].st, seq[i].pw, seq[i].pc);
      end
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (ex_now() !== exp) begin
        errors++;
        $display("FAIL branch ex[%0d]: got %h want %h", i, ex_now(), exp);
      end
    end
  endtask

  task automatic test_br_in_flush();
    cyc_t seq [4];
    logic [24:0] exp;
    seq = '{'{16'hF040, 1'b0, 1'b1, 8'h40, 1'b1},
            '{16'hF080, 1'b0, 1'b0, 8'h00, 1'b0},
            '{16'h1111, 1'b0, 1'b0, 8'h00, 1'b0},
            '{16'h0000, 1'b0, 1'b0, 8'h00, 1'b1}};
    do_reset();
    foreach (seq[i]) begin
      drive(seq[i].w, seq[i].iss);
      checks++;
      if (bus.stall !== seq[i].st || bus.pcWrEn !== seq[i].pw || (seq[i].pw && bus.newPc !== seq[i].pc)) begin
        errors++;
        $display("FAIL brflush ctrl[%0d]: stall/pcWrEn/newPc got %b/%b/%h want %b/%b/%h", i, bus.stall, bus.pcWrEn, bus.newPc, seq[i].st, seq[i].pw, seq[i].pc);
      end
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (ex_now() !== exp) begin
        errors++;
        $display("FAIL brflush ex[%0d]: got %h want %h", i, ex_now(), exp);
      end
    end
  endtask

  task automatic test_r0();
    cyc_t seq [3];
    logic [24:0] exp;
    seq = '{'{16'h1000, 1'b0, 1'b0, 8'h00, 1'b1},
            '{16'h2001, 1'b0, 1'b0, 8'h00, 1'b1},
            '{16'h3000, 1'b0, 1'b0, 8'h00, 1'b1}};
    do_reset();
    foreach (seq[i]) begin
      drive(seq[i].w, seq[i].iss);
      checks++;
      if (bus.stall !== seq[i].st || bus.pcWrEn !== seq[i].pw || (seq[i].pw && bus.newPc !== seq[i].pc)) begin
        errors++;
        $display("FAIL r0 ctrl[%0d]: stall/pcWrEn/newPc got %b/%b/%h want %b/%b/%h", i, bus.stall, bus.pcWrEn, bus.newPc, seq[i].st, seq[i].pw, seq[i].pc);
      end
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (ex_now() !== exp) begin
        errors++;
        $display("FAIL r0 ex[%0d]: got %h want %h", i, ex_now(), exp);
      end
    end
  endtask

  task automatic test_reset_in_stall();
    logic [24:0] exp;
    do_reset();
    drive(16'h1312, 1'b1);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (ex_now() !== exp) begin
      errors++;
      $display("FAIL rststall issue ex: got %h want %h", ex_now(), exp);
    end
    drive(16'h2435, 1'b0);
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL rststall stall: got %b want 1", bus.stall);
    end
    exp_q.delete();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.stall, bus.pcWrEn, bus.newPc} !== 10'd0 || ex_now() !== 25'd0) begin
      errors++;
      $display("FAIL rststall async: stall/pcWrEn/newPc got %b/%b/%h ex %h want all zero", bus.stall, bus.pcWrEn, bus.newPc, ex_now());
    end
    @(negedge clk);
    reset = 1'b1;
    bus.instruction = 16'h2435;
    exp_q.push_back(exp_of(16'h2435, 1'b1));
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL rststall post stall: got %b want 0", bus.stall);
    end
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (ex_now() !== exp) begin
      errors++;
      $display("FAIL rststall post ex: got %h want %h", ex_now(), exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.instruction = 16'h0000;
    test_reset();
    test_back_to_back();
    test_raw();
    test_store();
    test_branch();
    test_br_in_flush();
    test_r0();
    test_reset_in_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter WB_LAT, default 3, cycles from issue until a destination register may be read again (range 1..7).
REQ-002 Parameter NREG, default 16, architectural register count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 instruction  input  16  word from the fetch stage ROM, presented for the PC the fetch stage is loading this cycle.
REQ-006 stall  output  1  hold request to fetch: PC and instruction shall be held while high.
REQ-007 pcWrEn  output  1  one-cycle redirect strobe to fetch.
REQ-008 newPc  output  8  redirect target, valid while pcWrEn is high.
REQ-009 exValid  output  1  ID/EX slot holds a real instruction.
REQ-010 exOpcode, exRd, exRa, exRb  output  4 each  registered decoded fields.
REQ-011 exImm  output  8  registered instruction[7:0].

Function
REQ-012 Field map: opcode = [15:12], rd = [11:8], ra = [7:4], rb = [3:0], imm = [7:0].
REQ-013 Opcode classes: 0x0 NOP; 0x1..0xB write rd and read ra, rb; 0xC store (reads rd, ra, no write); 0xD..0xE reserved and treated as NOP; 0xF BR (unconditional, target imm, no register access).
REQ-014 The scoreboard holds one 3-bit down-counter per register; a register is pending while its counter is nonzero; register 0 is never pending.
REQ-015 On issue of a writer, counter[rd] loads WB_LAT; every other nonzero counter decrements by 1 each cycle; when load and decrement hit the same register, load wins.
REQ-016 Hazard = the current instruction reads a pending register; the unused rb of a store and all fields of NOP/BR are excluded.
REQ-017 The FSM has states RUN, STALL, FLUSH.
REQ-018 RUN with no hazard and not BR: the instruction issues, the ID/EX registers load the fields with exValid = 1, and the state stays RUN.
REQ-019 RUN with a hazard: stall = 1, exValid = 0 (bubble), the state goes to STALL, and the scoreboard keeps counting down.
REQ-020 STALL: stall stays 1 and the held instruction is re-evaluated every cycle; once the hazard is clear, stall drops combinationally, the instruction issues as in RUN, and the state returns to RUN.
REQ-021 RUN with BR: pcWrEn = 1 and newPc = imm for exactly one cycle, the BR is issued with exValid = 1, and the state goes to FLUSH with a flush counter of 2.
REQ-022 FLUSH: the instruction on the input is discarded (exValid = 0, no scoreboard load), the counter decrements, and the state returns to RUN when it reaches 0; the 2-cycle flush covers the fetch stage's one-cycle-delayed redirect.
REQ-023 A BR arriving in FLUSH is discarded and never redirects.
REQ-024 stall, pcWrEn and newPc are combinational from state, instruction and scoreboard; all ex* outputs are registered, giving a latency of 1 cycle from instruction to ex*.
REQ-025 pcWrEn and stall are never high in the same cycle.

Reset
REQ-026 While reset is low: state = RUN, all scoreboard counters = 0, flush counter = 0, exValid = 0, and all ex* fields = 0.
REQ-027 While reset is low, stall = 0, pcWrEn = 0 and newPc = 0.
REQ-028 Reset asserted mid-STALL or mid-FLUSH abandons the operation; the first instruction after release is decoded in RUN.

Structure
REQ-029 The opcode constants, the state enum {RUN, STALL, FLUSH}, and the class functions (writesRd, readsRa, readsRb, isBranch) shall live in a shared package asip_pkg.
REQ-030 The scoreboard shall be one sub-module, scoreboard, with ports issue, rd, ra, rb, the read-enable flags, and a hazard output.
REQ-031 The ID/EX register uses the codebase register module with a clear input for bubbles.

Verification
REQ-032 Back-to-back independent ALU ops 0x1123, 0x2456 -> exValid = 1 on consecutive cycles, with no stall.
REQ-033 RAW hazard: 0x1312 followed by 0x2435 (reads r3) with WB_LAT = 3 -> stall high for 3 cycles, 3 bubbles, then 0x2435 issues.
REQ-034 Branch 0xF040 -> pcWrEn = 1 and newPc = 0x40 for one cycle; the next two input words are discarded (exValid = 0), and the third issues.
REQ-035 BR inside the FLUSH window, e.g. 0xF040 then 0xF080 -> only one pcWrEn pulse, with newPc = 0x40.
REQ-036 Writes and reads of r0, e.g. 0x1000 then 0x2001 -> no stall.
REQ-037 Reset pulse during STALL -> all outputs go to 0 immediately; after release, scoreboard is clear and the next instruction issues without stall.
